// File: rtl/dmem_wait_if.sv
// dmem_wait_if: request/response bundle between the MEM stage (master)
// and the wait-state data memory (slave).
interface dmem_wait_if;
    logic [31:0] ip_data_addr;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        ip_data_rd;
    logic        op_data_ready;
    logic        op_data_valid;
    logic [31:0] op_data_from_dmem;
    logic        op_data_err;

    modport master (
        output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        input  op_data_ready, op_data_valid, op_data_from_dmem, op_data_err
    );

    modport slave (
        input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
        output op_data_ready, op_data_valid, op_data_from_dmem, op_data_err
    );
endinterface

// File: rtl/dmem_wait.sv
// dmem_wait: word-organised data memory with a registered read path,
// request/response handshake and WAIT_CYCLES programmable wait states.
// Optional macro DMEM_WAIT_PIPELINE_EN keeps ready high in RESP so a new
// request can be accepted on the edge that leaves RESP.
//
//   state | meaning
//   IDLE  | ready, waiting for rd/wr
//   WAIT  | request held, counting down wait states
//   RESP  | one-cycle response, valid (and err) high
module dmem_wait #(
    parameter int SIZE_IN_WORDS = 1024,
    parameter int WAIT_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_wait_if.slave  bus
);
    localparam int             IDX_W    = $clog2(SIZE_IN_WORDS);
    localparam bit             NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]     CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic               valid_q;
    logic               err_q;
    logic [31:0]        rdata_q;

    logic [IDX_W-1:0]   req_idx;
    logic               req_wr;
    logic               req_rd;
    logic [3:0]         req_mask;
    logic [31:0]        req_data;
    logic               req_err;

    logic [31:0]        mem [SIZE_IN_WORDS];

    logic               rdy_int;
    logic               accept;
    logic               in_err;
    logic               enter_resp;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_wr;
    logic               cur_rd;
    logic [3:0]         cur_mask;
    logic [31:0]        cur_data;
    logic               cur_err;
    logic               mem_we;

`ifdef DMEM_WAIT_PIPELINE_EN
    assign rdy_int = (state == ST_IDLE) || (state == ST_RESP);
`else
    assign rdy_int = (state == ST_IDLE);
`endif

    // Ready is forced low while reset is held, high as soon as it releases.
    assign bus.op_data_ready     = rdy_int & rst_n;
    assign bus.op_data_valid     = valid_q;
    assign bus.op_data_err       = err_q;
    assign bus.op_data_from_dmem = rdata_q;

    // Acceptance, error classification and selection of the request that
    // commits on this edge: live inputs when a zero-wait request goes
    // straight to RESP, otherwise the captured request leaving WAIT.
    always_comb begin
        accept     = bus.op_data_ready & (bus.ip_data_rd | bus.ip_data_wr);
        in_err     = ((bus.ip_data_addr >> (IDX_W + 2)) != 32'd0)
                   | (bus.ip_data_rd & bus.ip_data_wr)
                   | (bus.ip_data_wr & (bus.ip_data_mask == 4'b0000));
        enter_resp = (accept && NO_WAIT) || ((state == ST_WAIT) && (wait_cnt == 4'd0));
        if (accept) begin
            cur_idx  = bus.ip_data_addr[IDX_W+1:2];
            cur_wr   = bus.ip_data_wr;
            cur_rd   = bus.ip_data_rd;
            cur_mask = bus.ip_data_mask;
            cur_data = bus.ip_data_from_proc;
            cur_err  = in_err;
        end else begin
            cur_idx  = req_idx;
            cur_wr   = req_wr;
            cur_rd   = req_rd;
            cur_mask = req_mask;
            cur_data = req_data;
            cur_err  = req_err;
        end
        mem_we = enter_resp & cur_wr & ~cur_err;
    end

    // Control FSM, request capture and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            req_idx  <= '0;
            req_wr   <= 1'b0;
            req_rd   <= 1'b0;
            req_mask <= 4'd0;
            req_data <= 32'd0;
            req_err  <= 1'b0;
        end else begin
            valid_q <= enter_resp;
            err_q   <= enter_resp & cur_err;
            if (enter_resp && cur_rd && !cur_err) begin
                rdata_q <= mem[cur_idx];
            end
            if (accept) begin
                req_idx  <= bus.ip_data_addr[IDX_W+1:2];
                req_wr   <= bus.ip_data_wr;
                req_rd   <= bus.ip_data_rd;
                req_mask <= bus.ip_data_mask;
                req_data <= bus.ip_data_from_proc;
                req_err  <= in_err;
                if (NO_WAIT) begin
                    state <= ST_RESP;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= CNT_LOAD;
                end
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_WAIT: begin
                        if (wait_cnt == 4'd0) begin
                            state <= ST_RESP;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    ST_RESP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Storage: byte-lane write on the edge entering RESP; not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_mask[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: doc/dmem_wait.md
Name: dmem_wait

Overview:
- Word-organised data memory with a registered read path, a request/response handshake and a programmable number of wait states.
- Sits between the processor's MEM stage and the data storage, replacing the zero-latency asynchronous-read data memory.
- Honours the read strobe, acknowledges writes and flags out-of-range or malformed requests, so the pipeline can be exercised against slow memory.

Parameters:
- SIZE_IN_WORDS, 1024, number of 32-bit words; power of two, at least 4. Word index width IDX_W = $clog2(SIZE_IN_WORDS).
- WAIT_CYCLES, 0, extra cycles inserted between request acceptance and response; 0 to 15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ip_data_addr  input  32  byte address; word index is ip_data_addr[IDX_W+1:2].
- ip_data_wr  input  1  write request.
- ip_data_mask  input  4  byte-lane write enables; bit i enables byte i.
- ip_data_from_proc  input  32  write data, lane-aligned.
- ip_data_rd  input  1  read request.
- op_data_ready  output  1  block can accept a request this cycle.
- op_data_valid  output  1  one-cycle response pulse for reads, writes and errors.
- op_data_from_dmem  output  32  read data, registered.
- op_data_err  output  1  qualifies op_data_valid; request rejected.

Behaviour:
- Reset values: op_data_ready=1 after deassertion (0 while rst_n low), op_data_valid=0, op_data_err=0, op_data_from_dmem=0, state IDLE, wait counter 0. Memory array is not reset.
- Acceptance: a request is accepted on a rising edge where op_data_ready=1 and (ip_data_rd | ip_data_wr). At acceptance, addr, wr, rd, mask and data are captured into request registers. Inputs are don't-care in all other cycles.
- Error checks are evaluated at acceptance and captured with the request. A request is an error if any of the following holds:
  - ip_data_addr[31:IDX_W+2] != 0 (out of range);
  - rd and wr are both high;
  - wr is high with mask == 4'b0000.
- States:
  - IDLE: ready=1. On accept, go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
  - WAIT: ready=0. Decrement the counter each cycle. When the counter is 0, go to RESP on the next edge.
  - RESP: ready=0, valid=1 for exactly one cycle, then IDLE.
- Memory access happens on the edge that enters RESP:
  - Read: op_data_from_dmem <= mem[idx].
  - Write: each lane with mask[i]=1 is written; other lanes are unchanged.
  - Error: no memory access; op_data_err=1 during RESP; op_data_from_dmem is unchanged.
- op_data_from_dmem changes only on successful read responses and otherwise holds its last value.
- op_data_err is 0 whenever op_data_valid is 0.
- Latency: acceptance edge to valid = WAIT_CYCLES+1 cycles. Non-pipelined throughput is one request per WAIT_CYCLES+2 cycles.
- Read-after-write to the same word returns the new data, because the write commits before the later read can be accepted.
- Reset mid-operation: a pending request is discarded and a pending write is not performed. No valid pulse is produced, and state returns to IDLE.
- Address bits [1:0] are ignored for data placement; lane selection is by mask only.

Optional Feature:
- Macro: DMEM_WAIT_PIPELINE_EN.
- Defined: op_data_ready is also 1 in RESP, so a request accepted on the edge leaving RESP proceeds straight to WAIT/RESP. With WAIT_CYCLES=0, back-to-back requests complete one per cycle with valid held high continuously. A read accepted in RESP immediately after a write to the same word returns the written data (the write commits on the earlier edge).
- Undefined: behaviour exactly as above, with ready=0 in RESP.

Test Plan:
- WAIT_CYCLES=0:
  - Write 0xDEADBEEF, mask 1111, addr 0x10 -> valid 1 cycle after accept, err=0.
  - Read addr 0x10 -> valid 1 cycle after accept, data=0xDEADBEEF.
- Byte masks: word 0x10 = 0xDEADBEEF; write 0x00AA0055, mask 0101 -> subsequent read returns 0xDEAABE55.
- WAIT_CYCLES=3:
  - Read -> ready low for 4 cycles, valid on the 4th cycle after acceptance.
  - Rd held high continuously -> exactly one request accepted per 5 cycles.
- Errors:
  - Addr 0x1000 with SIZE_IN_WORDS=1024 -> valid+err, data unchanged, memory unchanged.
  - rd=wr=1 -> err.
  - wr with mask 0000 -> err.
- Reset mid-operation: assert rst_n=0 during WAIT of a write to 0x20 -> no valid pulse; a read of 0x20 after reset returns the old value; ready=1 after reset.
- With DMEM_WAIT_PIPELINE_EN, WAIT_CYCLES=0: issue write 0x20=0x12345678, then read 0x20 on consecutive cycles -> valid high 2 consecutive cycles, read data 0x12345678.
